// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the 6502 fetch front end.
// Also used by the decoder through opcode_length.
package cpu_fetch_pkg;

    typedef enum logic [2:0] {
        S_VEC_LO,
        S_VEC_HI,
        S_VEC_W,
        S_OP,
        S_OPW,
        S_LO,
        S_HI,
        S_OUT
    } fetch_state_t;

    localparam logic [15:0] VEC_RESET_LO = 16'hFFFC;
    localparam logic [15:0] VEC_RESET_HI = 16'hFFFD;
    localparam logic [7:0]  NOP_OPCODE   = 8'hEA;

    function automatic logic is_vec_state(input fetch_state_t s);
        return (s == S_VEC_LO) || (s == S_VEC_HI) || (s == S_VEC_W);
    endfunction

endpackage

// File: rtl/opcode_length.sv
// 6502 instruction length (1..3 bytes) decoded from the opcode alone.
// Purely combinational; undocumented c=11 opcodes are treated as single-byte.
module opcode_length
    import cpu_fetch_pkg::*;
(
    input  logic [7:0] i_op,
    output logic [1:0] o_len
);

    logic [2:0] w_a;
    logic [2:0] w_b;
    logic [1:0] w_c;

    assign w_a = i_op[7:5];
    assign w_b = i_op[4:2];
    assign w_c = i_op[1:0];

    always_comb begin
        o_len = 2'd1;
        case (w_c)
            2'b01: begin
                if (w_b == 3'b011 || w_b == 3'b110 || w_b == 3'b111) o_len = 2'd3;
                else                                                  o_len = 2'd2;
            end
            2'b10: begin
                if (w_b == 3'b011 || w_b == 3'b111)                        o_len = 2'd3;
                else if (w_b == 3'b001 || w_b == 3'b101 || i_op == 8'hA2) o_len = 2'd2;
            end
            2'b00: begin
                // JSR is the only b=000 opcode with an absolute operand
                if (i_op == 8'h20)                                         o_len = 2'd3;
                else if (w_b == 3'b000 && w_a >= 3'd4)                    o_len = 2'd2;
                else if (w_b == 3'b011 || w_b == 3'b111)                  o_len = 2'd3;
                else if (w_b == 3'b001 || w_b == 3'b100 || w_b == 3'b101) o_len = 2'd2;
            end
            default: o_len = 2'd1;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// 6502 instruction fetch: optional reset-vector load, then opcode plus operand
// byte assembly, presented as one bundle over a valid/ready handshake.
module instr_fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter int          VECTOR_FETCH = 1,
    parameter logic [15:0] RESET_PC     = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    input  logic        pc_load,
    input  logic [15:0] pc_load_addr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [7:0]  opcode,
    output logic [7:0]  operand_lo,
    output logic [7:0]  operand_hi,
    output logic [1:0]  instr_len,
    output logic [15:0] instr_pc,
    output logic [15:0] fetch_pc
);

    fetch_state_t r_state;
    logic         r_valid;
    logic [7:0]   r_opcode;
    logic [7:0]   r_lo;
    logic [7:0]   r_hi;
    logic [1:0]   r_len;
    logic [15:0]  r_instr_pc;
    logic [15:0]  r_fetch_pc;
    logic [15:0]  r_mem_addr;

    logic [1:0]   w_len;
    logic         w_issue;
    logic [15:0]  w_issue_addr;
    logic         w_redirect;
    logic         w_accept;

    opcode_length u_len (
        .i_op  (mem_rdata),
        .o_len (w_len)
    );

    assign w_redirect = pc_load && !is_vec_state(r_state);
    assign w_accept   = r_valid && instr_ready;

    // Read strobe is decoded from the state so data returns in the very next
    // state; suppressed while rst is held so no read is issued during reset.
    always_comb begin
        w_issue      = 1'b0;
        w_issue_addr = r_mem_addr;
        case (r_state)
            S_VEC_LO: begin
                w_issue      = 1'b1;
                w_issue_addr = VEC_RESET_LO;
            end
            S_VEC_HI: begin
                w_issue      = 1'b1;
                w_issue_addr = VEC_RESET_HI;
            end
            S_OP: begin
                w_issue      = 1'b1;
                w_issue_addr = r_fetch_pc;
            end
            S_OPW: begin
                if (w_len != 2'd1) begin
                    w_issue      = 1'b1;
                    w_issue_addr = r_fetch_pc + 16'd1;
                end
            end
            S_LO: begin
                if (r_len == 2'd3) begin
                    w_issue      = 1'b1;
                    w_issue_addr = r_fetch_pc + 16'd2;
                end
            end
            default: ;
        endcase
        if (rst) begin
            w_issue      = 1'b0;
            w_issue_addr = r_mem_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= (VECTOR_FETCH != 0) ? S_VEC_LO : S_OP;
            r_valid    <= 1'b0;
            r_opcode   <= NOP_OPCODE;
            r_lo       <= 8'h00;
            r_hi       <= 8'h00;
            r_len      <= 2'd1;
            r_instr_pc <= 16'h0000;
            r_fetch_pc <= RESET_PC;
            r_mem_addr <= 16'h0000;
        end else begin
            if (w_issue) r_mem_addr <= w_issue_addr;
            // A redirect wins over everything, including a same-cycle accept;
            // whatever read is in flight lands in S_OP and is dropped.
            if (w_redirect) begin
                r_fetch_pc <= pc_load_addr;
                r_valid    <= 1'b0;
                r_state    <= S_OP;
            end else begin
                case (r_state)
                    S_VEC_LO: r_state <= S_VEC_HI;
                    S_VEC_HI: begin
                        r_fetch_pc[7:0] <= mem_rdata;
                        r_state         <= S_VEC_W;
                    end
                    S_VEC_W: begin
                        r_fetch_pc[15:8] <= mem_rdata;
                        r_state          <= S_OP;
                    end
                    S_OP: r_state <= S_OPW;
                    S_OPW: begin
                        r_opcode   <= mem_rdata;
                        r_len      <= w_len;
                        r_lo       <= 8'h00;
                        r_hi       <= 8'h00;
                        r_instr_pc <= r_fetch_pc;
                        if (w_len == 2'd1) begin
                            r_valid <= 1'b1;
                            r_state <= S_OUT;
                        end else begin
                            r_state <= S_LO;
                        end
                    end
                    S_LO: begin
                        r_lo <= mem_rdata;
                        if (r_len == 2'd3) begin
                            r_state <= S_HI;
                        end else begin
                            r_valid <= 1'b1;
                            r_state <= S_OUT;
                        end
                    end
                    S_HI: begin
                        r_hi    <= mem_rdata;
                        r_valid <= 1'b1;
                        r_state <= S_OUT;
                    end
                    S_OUT: begin
                        if (w_accept) begin
                            r_fetch_pc <= r_fetch_pc + {14'd0, r_len};
                            r_valid    <= 1'b0;
                            r_state    <= S_OP;
                        end
                    end
                    default: r_state <= S_OP;
                endcase
            end
        end
    end

    assign mem_rd      = w_issue;
    assign mem_addr    = w_issue_addr;
    assign instr_valid = r_valid;
    assign opcode      = r_opcode;
    assign operand_lo  = r_lo;
    assign operand_hi  = r_hi;
    assign instr_len   = r_len;
    assign instr_pc    = r_instr_pc;
    assign fetch_pc    = r_fetch_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: vector-fetch instance with directed
// program, plus a second instance started at FFFE for address wrap.
module tb_instr_fetch_unit;

    typedef struct packed {
        logic [7:0]  op;
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [1:0]  len;
        logic [15:0] pc;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  mem [0:65535];

    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata = 8'h00;
    logic        pc_load = 1'b0;
    logic [15:0] pc_load_addr = 16'h0000;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [7:0]  opcode;
    logic [7:0]  operand_lo;
    logic [7:0]  operand_hi;
    logic [1:0]  instr_len;
    logic [15:0] instr_pc;
    logic [15:0] fetch_pc;

    logic [15:0] mem_addr2;
    logic        mem_rd2;
    logic [7:0]  mem_rdata2 = 8'h00;
    logic        pc_load2 = 1'b0;
    logic [15:0] pc_load_addr2 = 16'h0000;
    logic        instr_valid2;
    logic        instr_ready2 = 1'b1;
    logic [7:0]  opcode2;
    logic [7:0]  operand_lo2;
    logic [7:0]  operand_hi2;
    logic [1:0]  instr_len2;
    logic [15:0] instr_pc2;
    logic [15:0] fetch_pc2;

    bundle_t exp_q[$];
    int      checks = 0;
    int      failures = 0;
    int      mon_cyc = 0;
    int      op_cyc = -1;
    logic    prev_valid = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.VECTOR_FETCH(1), .RESET_PC(16'h0000)) u_dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .pc_load(pc_load), .pc_load_addr(pc_load_addr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .opcode(opcode), .operand_lo(operand_lo),
        .operand_hi(operand_hi), .instr_len(instr_len), .instr_pc(instr_pc), .fetch_pc(fetch_pc)
    );

    instr_fetch_unit #(.VECTOR_FETCH(0), .RESET_PC(16'hFFFE)) u_dut_wrap (
        .clk(clk), .rst(rst), .mem_addr(mem_addr2), .mem_rd(mem_rd2), .mem_rdata(mem_rdata2),
        .pc_load(pc_load2), .pc_load_addr(pc_load_addr2), .instr_valid(instr_valid2),
        .instr_ready(instr_ready2), .opcode(opcode2), .operand_lo(operand_lo2),
        .operand_hi(operand_hi2), .instr_len(instr_len2), .instr_pc(instr_pc2), .fetch_pc(fetch_pc2)
    );

    always @(posedge clk) begin
        if (mem_rd)  mem_rdata  <= mem[mem_addr];
        if (mem_rd2) mem_rdata2 <= mem[mem_addr2];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic bundle_t mk(input logic [7:0] op, input logic [7:0] lo, input logic [7:0] hi,
                                   input logic [1:0] len, input logic [15:0] pc);
        return {op, lo, hi, len, pc};
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_ctl"}, 64'({instr_valid, mem_rd, mem_addr, fetch_pc}),
              64'({1'b0, 1'b0, 16'h0000, 16'h0000}));
        check({tag, "_bundle"}, 64'({opcode, operand_lo, operand_hi, instr_len, instr_pc}),
              64'({8'hEA, 8'h00, 8'h00, 2'd1, 16'h0000}));
    endtask

    // Monitor: pops and compares on every handshake, and measures the
    // opcode-read to valid latency of the bundle at the head of the queue.
    initial begin : monitor
        bundle_t act;
        bundle_t exp;
        forever begin
            @(negedge clk);
            #1;
            mon_cyc++;
            if (!rst && exp_q.size() != 0 && mem_rd && mem_addr == exp_q[0].pc && op_cyc < 0)
                op_cyc = mon_cyc;
            if (instr_valid && !prev_valid && exp_q.size() != 0)
                check("latency", 64'((op_cyc < 0) ? 999 : (mon_cyc - op_cyc)), 64'(exp_q[0].len + 1));
            if (instr_valid && instr_ready) begin
                act = {opcode, operand_lo, operand_hi, instr_len, instr_pc};
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_bundle actual=%h required=none", act);
                end else begin
                    exp = exp_q.pop_front();
                    check("bundle", 64'(act), 64'(exp));
                    op_cyc = -1;
                end
            end
            prev_valid = instr_valid;
        end
    end

    initial begin : wrap_check
        int n2;
        @(negedge clk);
        while (rst) @(negedge clk);
        n2 = 0;
        while (!instr_valid2 && n2 < 20) begin
            @(negedge clk);
            n2++;
        end
        check("wrap_wait", 64'(n2 < 20), 64'(1));
        check("wrap_bundle", 64'({opcode2, operand_lo2, operand_hi2, instr_len2, instr_pc2}),
              64'({8'hAD, 8'h00, 8'hC0, 2'd3, 16'hFFFE}));
        @(negedge clk);
        check("wrap_fetch_pc", 64'(fetch_pc2), 64'(16'h0001));
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int n;
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
        mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
        mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h55; mem[16'h8002] = 8'hEA;
        mem[16'h8003] = 8'h4C; mem[16'h8004] = 8'h34; mem[16'h8005] = 8'h12;
        mem[16'h8006] = 8'h85; mem[16'h8007] = 8'h10;
        mem[16'h8008] = 8'hAD; mem[16'h8009] = 8'h11; mem[16'h800A] = 8'h22;
        mem[16'h1234] = 8'hA2; mem[16'h1235] = 8'h77; mem[16'h1236] = 8'hEA;
        mem[16'h2000] = 8'h20; mem[16'h2001] = 8'h00; mem[16'h2002] = 8'h30;
        mem[16'h2003] = 8'hC0; mem[16'h2004] = 8'h44; mem[16'h2005] = 8'h00;
        mem[16'h2006] = 8'hBE; mem[16'h2007] = 8'h00; mem[16'h2008] = 8'h10;
        mem[16'h2009] = 8'h03;
        mem[16'hFFFE] = 8'hAD; mem[16'hFFFF] = 8'h00; mem[16'h0000] = 8'hC0;

        repeat (3) @(negedge clk);
        check_reset("reset");
        check("reset_wrap_fetch_pc", 64'({mem_rd2, fetch_pc2}), 64'({1'b0, 16'hFFFE}));

        exp_q.push_back(mk(8'hA9, 8'h55, 8'h00, 2'd2, 16'h8000));
        exp_q.push_back(mk(8'hEA, 8'h00, 8'h00, 2'd1, 16'h8002));
        exp_q.push_back(mk(8'h4C, 8'h34, 8'h12, 2'd3, 16'h8003));
        exp_q.push_back(mk(8'h85, 8'h10, 8'h00, 2'd2, 16'h8006));
        exp_q.push_back(mk(8'hA2, 8'h77, 8'h00, 2'd2, 16'h1234));
        exp_q.push_back(mk(8'hEA, 8'h00, 8'h00, 2'd1, 16'h1236));
        exp_q.push_back(mk(8'h20, 8'h00, 8'h30, 2'd3, 16'h2000));
        exp_q.push_back(mk(8'hC0, 8'h44, 8'h00, 2'd2, 16'h2003));
        exp_q.push_back(mk(8'h00, 8'h00, 8'h00, 2'd1, 16'h2005));
        exp_q.push_back(mk(8'hBE, 8'h00, 8'h10, 2'd3, 16'h2006));
        exp_q.push_back(mk(8'h03, 8'h00, 8'h00, 2'd1, 16'h2009));
        rst = 1'b0;
        instr_ready = 1'b1;

        // Redirect while the AD at 8008 is reading its high operand (S_LO)
        n = 0;
        while (!(mem_rd && mem_addr == 16'h800A) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("redirect_wait", 64'(n < 200), 64'(1));
        pc_load = 1'b1;
        pc_load_addr = 16'h1234;
        instr_ready = 1'b0;
        @(negedge clk);
        pc_load = 1'b0;
        check("redirect_addr", 64'({mem_rd, mem_addr, fetch_pc}), 64'({1'b1, 16'h1234, 16'h1234}));

        // Backpressure on the A2 bundle
        n = 0;
        while (!instr_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_wait", 64'(n < 50), 64'(1));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold", 64'({instr_valid, mem_rd, fetch_pc, opcode, operand_lo}),
                  64'({1'b1, 1'b0, 16'h1234, 8'hA2, 8'h77}));
        end
        instr_ready = 1'b1;
        @(negedge clk);
        check("bp_advance", 64'(fetch_pc), 64'(16'h1236));
        instr_ready = 1'b0;

        // Handshake and redirect in the same cycle
        n = 0;
        while (!instr_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("sim_wait", 64'(n < 50), 64'(1));
        instr_ready = 1'b1;
        pc_load = 1'b1;
        pc_load_addr = 16'h2000;
        @(negedge clk);
        pc_load = 1'b0;
        check("sim_redirect", 64'({mem_rd, mem_addr, fetch_pc, instr_valid}),
              64'({1'b1, 16'h2000, 16'h2000, 1'b0}));

        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_program", 64'(n < 500), 64'(1));

        // Reset in the middle of the next opcode fetch
        instr_ready = 1'b0;
        check("midfetch_rd", 64'({mem_rd, mem_addr}), 64'({1'b1, 16'h200A}));
        rst = 1'b1;
        @(negedge clk);
        check_reset("midreset");
        exp_q.push_back(mk(8'hA9, 8'h55, 8'h00, 2'd2, 16'h8000));
        rst = 1'b0;
        instr_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_restart", 64'(n < 200), 64'(1));
        instr_ready = 1'b0;
        check("restart_fetch_pc", 64'(fetch_pc), 64'(16'h8002));
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream stage of the 6502 core. Walks program memory from the PC, assembles each instruction (opcode plus 0–2 operand bytes) and presents it to the instruction decoder and register file over a valid/ready handshake.
- Owns the architectural fetch PC and accepts PC redirects from JMP and branch execution.
- Optionally performs the reset-vector fetch (FFFC/FFFD) before the first opcode fetch.

Parameters:
- VECTOR_FETCH, 1: 1 means the start PC is read from FFFC/FFFD after reset; 0 means the start PC is RESET_PC.
- RESET_PC, 16'h0000: start PC when VECTOR_FETCH=0.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- mem_addr  output  16  read address
- mem_rd  output  1  read strobe
- mem_rdata  input  8  read data, valid exactly 1 cycle after mem_rd
- pc_load  input  1  redirect request (1-cycle pulse)
- pc_load_addr  input  16  redirect target
- instr_valid  output  1  instruction bundle valid
- instr_ready  input  1  consumer accepts bundle
- opcode  output  8  fetched opcode
- operand_lo  output  8  first operand byte (00 if absent)
- operand_hi  output  8  second operand byte (00 if absent)
- instr_len  output  2  instruction length, 1..3
- instr_pc  output  16  address of opcode
- fetch_pc  output  16  current fetch PC

Behaviour:
- Clocking: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - instr_valid=0, mem_rd=0, mem_addr=0000.
  - opcode=EA, operand_lo=00, operand_hi=00, instr_len=1, instr_pc=0000.
  - fetch_pc=RESET_PC.
  - Next state is S_VEC_LO if VECTOR_FETCH=1, otherwise S_OP.
- States (one mem_rd per issuing state):
  - S_VEC_LO: rd FFFC → S_VEC_HI.
  - S_VEC_HI: capture rdata into fetch_pc[7:0]; rd FFFD → S_VEC_W.
  - S_VEC_W: capture rdata into fetch_pc[15:8] → S_OP.
  - S_OP: rd fetch_pc → S_OPW.
  - S_OPW: latch opcode=rdata; len=L(rdata); clear operand bytes to 00. If len=1 → S_OUT, else rd fetch_pc+1 → S_LO.
  - S_LO: latch operand_lo=rdata. If len=3, rd fetch_pc+2 → S_HI, else → S_OUT.
  - S_HI: latch operand_hi=rdata → S_OUT.
  - S_OUT: instr_valid=1, bundle held stable. On instr_ready: fetch_pc += len → S_OP.
- Latency from S_OP entry to instr_valid: 2 cycles for len1, 3 for len2, 4 for len3. A bundle is accepted at most every len+2 cycles.
- Length function L(op), with a=op[7:5], b=op[4:2], c=op[1:0]:
  - c=01: len 3 if b ∈ {011, 110, 111}, else 2.
  - c=10: len 3 if b ∈ {011, 111}; len 2 if b ∈ {001, 101} or op=A2; else 1.
  - c=00:
    - op=20: 3.
    - b=000 and a≥100: 2.
    - b ∈ {011, 111}: 3.
    - b ∈ {001, 100, 101}: 2.
    - else: 1.
  - c=11 (illegal): 1.
  - BRK (00) is len 1.
- Arithmetic: all address arithmetic is mod 2^16. FFFF+1 reads 0000; FFFE with len3 reads FFFF then 0000.
- pc_load:
  - Highest priority in every state except the vector states.
  - fetch_pc=pc_load_addr, instr_valid=0 next cycle, next state S_OP.
  - An in-flight read result arriving next cycle is discarded.
  - If pc_load coincides with the valid&ready handshake, the bundle counts as transferred and the load address wins over pc+len.
  - pc_load during the vector states is ignored.
- rst asserted in any state, including mid-fetch: returns to reset values next cycle; rdata of the aborted read is ignored.
- instr_ready while instr_valid=0 has no effect.
- mem_rd is asserted only in issuing states; mem_addr holds its last value otherwise.

Decomposition:
- Shared package cpu_fetch_pkg:
  - fetch_state_t enum.
  - VEC_RESET_LO=16'hFFFC, VEC_RESET_HI=16'hFFFD.
  - NOP_OPCODE=8'hEA.
- One combinational sub-module, opcode_length (op[7:0] → len[1:0]), implementing L(op). It is reusable by the decoder.

Test Plan:
- Reset vector: VECTOR_FETCH=1, mem FFFC=00, FFFD=80, 8000=A9, 8001=55, instr_ready=1 → first bundle opcode=A9, operand_lo=55, len=2, instr_pc=8000; next fetch at 8002.
- Length sweep: memory holds EA; 4C 34 12; 85 10 → bundles len 1/3/2, operand_hi=12 for 4C; valid 2/4/3 cycles after S_OP.
- Backpressure: instr_ready=0 for 10 cycles in S_OUT → bundle stable, mem_rd=0, fetch_pc unchanged; ready=1 → fetch_pc advances by len.
- Redirect: pc_load=1 with pc_load_addr=1234 during S_LO of a 3-byte fetch → no bundle for the aborted instruction; next mem_addr=1234.
- Simultaneous handshake and pc_load=1 with target 2000 in S_OUT → bundle consumed once; next opcode read at 2000, not pc+len.
- Wrap: RESET_PC=FFFE, VECTOR_FETCH=0, mem FFFE=AD, FFFF=00, 0000=C0 → len=3, operand_lo=00, operand_hi=C0; fetch_pc becomes 0001.
